data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, the number of 32-bit words in the attached dataMemory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1, input, 1 each, the access request from port 0 (CPU) and port 1 (DMA).
REQ-005 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read, held stable while reqN=1 and ackN=0.
REQ-006 SHALL have ports addr0/addr1, input, 32 each, the byte address, held stable with reqN.
REQ-007 SHALL have ports wdata0/wdata1, input, 32 each, the write data, held stable with reqN.
REQ-008 SHALL have ports ack0/ack1, output, 1 each, a one-cycle completion pulse.
REQ-009 SHALL have ports rdata0/rdata1, output, 32 each, the read data, valid while ackN=1.
REQ-010 SHALL have ports err0/err1, output, 1 each, an error flag, valid while ackN=1.
REQ-011 SHALL have port mem_address, output, 32, driving dataMemory address.
REQ-012 SHALL have port mem_wrEn, output, 1, driving dataMemory wrEn.
REQ-013 SHALL have port mem_data_in, output, 32, driving dataMemory data_in.
REQ-014 SHALL have port mem_data_out, input, 32, from dataMemory data_out (combinational read).
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, one cycle per state when leaving IDLE.
REQ-017 In IDLE with no request: SHALL stay in IDLE; all mem_* outputs SHALL be 0.
REQ-018 In IDLE with any request: SHALL select a winner, latch its we/addr/wdata and port id, set mem_address/mem_data_in to the latched values and mem_wrEn to the latched we, then go to ACCESS; mem_* outputs are registered.
REQ-019 Arbitration: a single requester SHALL win; if both request, the port not granted last SHALL win (round-robin); last_grant SHALL update on every grant.
REQ-020 In ACCESS: mem_* SHALL hold the latched values, and mem_data_out SHALL be captured into the winner's rdata register at the cycle end; next state is RESP.
REQ-021 Leaving ACCESS: mem_wrEn, mem_address and mem_data_in SHALL return to 0.
REQ-022 In RESP: ackN SHALL be 1 for the winner only, for exactly one cycle; next state is IDLE.
REQ-023 Latency: ackN SHALL assert 2 cycles after the IDLE cycle that sampled reqN; maximum throughput is one access per 3 cycles.
REQ-024 reqN during RESP SHALL be ignored; the requester drops req on the edge where it sees ack; a req high in the following IDLE is a new request.
REQ-025 Error check in IDLE: addr[1:0] != 0, or addr[31:2] >= MEM_WORDS, SHALL flag the access as an error.
REQ-026 An errored access SHALL still take the ACCESS and RESP states but with mem_wrEn=0; RESP SHALL give errN=1 and rdataN=0.
REQ-027 For a good write, rdataN SHALL equal mem_data_out sampled in ACCESS; errN SHALL be 0 on all good accesses.
REQ-028 The losing port's ack, err and rdata outputs SHALL stay 0 while a grant is in progress.
REQ-029 Memory address SHALL pass through unmodified as the byte address; word index = addr[31:2].

Reset
REQ-030 While reset=1 at a rising edge, the following SHALL apply: state=IDLE, last_grant=1 (port 0 wins the first tie), mem_address=0, mem_wrEn=0, mem_data_in=0, ack0/1=0, err0/1=0, rdata0/1=0, busy=0.
REQ-031 Reset mid-operation (ACCESS or RESP) SHALL abort the access, so no ack is issued; a write already driven during that ACCESS cycle is not undone.
REQ-032 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-033 Only port 0: read addr 0x00000000, memory word0=0xFFFFFFFF -> mem_wrEn stays 0; ack0 at cycle +2; rdata0=0xFFFFFFFF; err0=0.
REQ-034 Only port 0: write addr 0x00000004 with data 0x00000001 -> mem_wrEn=1 in ACCESS only; dMem[1]=0x00000001; ack0 pulse; busy high for 2 cycles.
REQ-035 Both ports request in the same cycle after reset: port 1 writes 0xFFFFFFFF at 0x00000008 -> port 0 is served first; then port 1 at the next IDLE; dMem[2]=0xFFFFFFFF; the acks never overlap.
REQ-036 Port 1 writes addr 0x00000006 (misaligned) and then 0x00000400 (with MEM_WORDS=256) -> mem_wrEn stays 0; ack1=1 with err1=1 and rdata1=0 for each.
REQ-037 Both ports hold req high continuously for 12 cycles -> grants alternate 0,1,0,1; each ack pulse is 3 cycles apart.
REQ-038 Reset asserted in the ACCESS cycle of a port 0 write -> next cycle state=IDLE, ack0 never asserts, all outputs are 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port data memory with a combinational read.
// Each access walks IDLE -> ACCESS -> RESP; ties are broken round-robin.
module data_mem_arbiter #(
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] mem_address,
   output logic        mem_wrEn,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state, state_n;
   logic        last_grant, last_grant_n;
   logic        grant_id, grant_id_n;
   logic        acc_err, acc_err_n;
   logic [31:0] mem_address_n, mem_data_in_n;
   logic        mem_wrEn_n;
   logic        ack0_n, ack1_n, err0_n, err1_n;
   logic [31:0] rdata0_n, rdata1_n;

   logic        win;
   logic        win_we;
   logic [31:0] win_addr, win_wdata;
   logic        win_err;

   always_comb begin
      // On a tie the port that did not win last time gets the grant.
      win       = (req0 && req1) ? ~last_grant : req1;
      win_we    = win ? we1 : we0;
      win_addr  = win ? addr1 : addr0;
      win_wdata = win ? wdata1 : wdata0;
      win_err   = (win_addr[1:0] != 2'b00) ||
                  ({1'b0, win_addr[31:2]} >= 31'(MEM_WORDS));
   end

   always_comb begin
      state_n       = state;
      last_grant_n  = last_grant;
      grant_id_n    = grant_id;
      acc_err_n     = acc_err;
      mem_address_n = mem_address;
      mem_wrEn_n    = mem_wrEn;
      mem_data_in_n = mem_data_in;
      ack0_n        = 1'b0;
      ack1_n        = 1'b0;
      err0_n        = 1'b0;
      err1_n        = 1'b0;
      rdata0_n      = '0;
      rdata1_n      = '0;
      unique case (state)
         IDLE: begin
            mem_address_n = '0;
            mem_wrEn_n    = 1'b0;
            mem_data_in_n = '0;
            if (req0 || req1) begin
               grant_id_n    = win;
               last_grant_n  = win;
               acc_err_n     = win_err;
               mem_address_n = win_addr;
               mem_data_in_n = win_wdata;
               mem_wrEn_n    = win_we && !win_err;
               state_n       = ACCESS;
            end
         end
         ACCESS: begin
            mem_address_n = '0;
            mem_wrEn_n    = 1'b0;
            mem_data_in_n = '0;
            state_n       = RESP;
            // Response registers load here so ack/err/rdata appear together in RESP.
            if (grant_id) begin
               ack1_n   = 1'b1;
               err1_n   = acc_err;
               rdata1_n = acc_err ? '0 : mem_data_out;
            end else begin
               ack0_n   = 1'b1;
               err0_n   = acc_err;
               rdata0_n = acc_err ? '0 : mem_data_out;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         grant_id    <= 1'b0;
         acc_err     <= 1'b0;
         mem_address <= '0;
         mem_wrEn    <= 1'b0;
         mem_data_in <= '0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err0        <= 1'b0;
         err1        <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
      end else begin
         state       <= state_n;
         last_grant  <= last_grant_n;
         grant_id    <= grant_id_n;
         acc_err     <= acc_err_n;
         mem_address <= mem_address_n;
         mem_wrEn    <= mem_wrEn_n;
         mem_data_in <= mem_data_in_n;
         ack0        <= ack0_n;
         ack1        <= ack1_n;
         err0        <= err0_n;
         err1        <= err1_n;
         rdata0      <= rdata0_n;
         rdata1      <= rdata1_n;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios then random two-port traffic,
// checked every cycle against a transaction-level model with its own memory image.
module tb_data_mem_arbiter;

   localparam int unsigned MEM_WORDS = 256;
   localparam int unsigned AW = $clog2(MEM_WORDS);

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_address, mem_data_in, mem_data_out;
   logic        mem_wrEn, busy;
   logic        load_en;

   logic [31:0] dmem    [0:MEM_WORDS-1];
   logic [31:0] ref_mem [0:MEM_WORDS-1];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int g     = -100;
   int last  = 1;

   req_t q0[$];
   req_t q1[$];
   req_t cur0, cur1;
   logic active0 = 1'b0;
   logic active1 = 1'b0;

   int          t_port;
   logic        t_we, t_err;
   logic [31:0] t_addr, t_wdata, t_rdata;

   always #5 clk = ~clk;

   data_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1),
      .mem_address(mem_address), .mem_wrEn(mem_wrEn),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .busy(busy)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'hFFFF_FFFF;
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   // Attached memory: combinational read, write on the rising edge.
   assign mem_data_out = (mem_address[31:2] < 30'(MEM_WORDS)) ? dmem[mem_address[AW+1:2]] : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= init_word(i);
      end else if (mem_wrEn && (mem_address[31:2] < 30'(MEM_WORDS))) begin
         dmem[mem_address[AW+1:2]] <= mem_data_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic acc, rsp, a0, a1;
      acc = (cyc == g + 1);
      rsp = (cyc == g + 2);
      a0  = rsp && (t_port == 0);
      a1  = rsp && (t_port == 1);
      chk("busy",        32'(busy),     32'(acc || rsp));
      chk("mem_wrEn",    32'(mem_wrEn), 32'(acc && t_we && !t_err));
      chk("mem_address", mem_address,   acc ? t_addr : 32'h0);
      chk("mem_data_in", mem_data_in,   acc ? t_wdata : 32'h0);
      chk("ack0",        32'(ack0),     32'(a0));
      chk("ack1",        32'(ack1),     32'(a1));
      chk("err0",        32'(err0),     32'(a0 && t_err));
      chk("err1",        32'(err1),     32'(a1 && t_err));
      chk("rdata0",      rdata0,        a0 ? t_rdata : 32'h0);
      chk("rdata1",      rdata1,        a1 ? t_rdata : 32'h0);
   endtask

   task automatic push0(input logic we, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      q0.push_back(r);
   endtask

   task automatic push1(input logic we, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      q1.push_back(r);
   endtask

   // One clock: check this cycle, let requesters react to ack, decide the model's grant.
   task automatic step();
      int   win;
      req_t w;
      logic [29:0] idx;
      @(negedge clk);
      check_outputs();
      if (cyc == g + 2) begin
         if (t_port == 0) active0 = 1'b0; else active1 = 1'b0;
      end
      if (!active0 && q0.size() > 0) begin cur0 = q0.pop_front(); active0 = 1'b1; end
      if (!active1 && q1.size() > 0) begin cur1 = q1.pop_front(); active1 = 1'b1; end
      req0 = active0; we0 = active0 && cur0.we;
      addr0 = active0 ? cur0.addr : 32'h0; wdata0 = active0 ? cur0.wdata : 32'h0;
      req1 = active1; we1 = active1 && cur1.we;
      addr1 = active1 ? cur1.addr : 32'h0; wdata1 = active1 ? cur1.wdata : 32'h0;
      if (cyc > g + 2 && (active0 || active1)) begin
         if (active0 && active1) win = (last == 1) ? 0 : 1;
         else                    win = active0 ? 0 : 1;
         w       = (win == 0) ? cur0 : cur1;
         last    = win;
         g       = cyc;
         t_port  = win;
         t_we    = w.we;
         t_addr  = w.addr;
         t_wdata = w.wdata;
         idx     = w.addr[31:2];
         t_err   = (w.addr % 4 != 0) || (int'(idx) >= MEM_WORDS);
         t_rdata = t_err ? 32'h0 : ref_mem[idx];
         if (w.we && !t_err) ref_mem[idx] = w.wdata;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      check_outputs();
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      active0 = 1'b0; active1 = 1'b0;
      q0.delete(); q1.delete();
      g = -100; last = 1;
      @(posedge clk);
      cyc++;
      #1 reset = 1'b0;
   endtask

   task automatic run_idle(input int bound);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || active0 || active1 || cyc <= g + 2) && n < bound) begin
         step();
         n++;
      end
      total++;
      assert (n < bound) else begin
         bad++;
         $error("FAIL drain_timeout observed=%0d expected<%0d", n, bound);
      end
   endtask

   task automatic push_random(input int port);
      logic        we;
      logic [31:0] a;
      int          sel;
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
      else if (sel == 8) a = 32'($urandom_range(0, MEM_WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
      else               a = 32'(MEM_WORDS + $urandom_range(0, 1000)) * 4;
      if (port == 0) push0(we, a, $urandom);
      else           push1(we, a, $urandom);
   endtask

   initial begin
      reset = 1'b1; load_en = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; load_en = 1'b0;

      // Reset state, then a single read of word 0 and a single write of word 1.
      step();
      push0(1'b0, 32'h0000_0000, 32'h0);
      run_idle(20);
      push0(1'b1, 32'h0000_0004, 32'h0000_0001);
      run_idle(20);

      // Tie straight after reset: port 0 first, then port 1's write.
      do_reset();
      push0(1'b0, 32'h0000_000C, 32'h0);
      push1(1'b1, 32'h0000_0008, 32'hFFFF_FFFF);
      run_idle(30);

      // Misaligned and out-of-range accesses from port 1.
      push1(1'b1, 32'h0000_0006, 32'h1234_5678);
      push1(1'b1, 32'h0000_0400, 32'h8765_4321);
      run_idle(30);

      // Both ports held busy: grants alternate.
      for (int i = 0; i < 4; i++) begin
         push0(1'(i % 2), 32'(16 + i) * 4, 32'hA000_0000 + 32'(i));
         push1(1'((i + 1) % 2), 32'(32 + i) * 4, 32'hB000_0000 + 32'(i));
      end
      run_idle(40);

      // Reset during the ACCESS cycle of a port 0 write: no ack afterwards, write stays.
      push0(1'b1, 32'h0000_0010, 32'hCAFE_F00D);
      begin
         int n = 0;
         do begin step(); n++; end while (g != cyc - 1 && n < 10);
         total++;
         assert (g == cyc - 1) else begin
            bad++;
            $error("FAIL reach_access observed=%0d expected=%0d", cyc, g + 1);
         end
      end
      do_reset();
      repeat (5) step();

      // Random two-port traffic.
      repeat (400) begin
         if (q0.size() == 0 && $urandom_range(0, 2) != 0) push_random(0);
         if (q1.size() == 0 && $urandom_range(0, 2) != 0) push_random(1);
         step();
      end
      run_idle(40);

      for (int i = 0; i < MEM_WORDS; i++) chk("dmem", dmem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
